// File: rtl/cp_bufwrap_arb.sv
// Single-port SRAM wrapper: posted-write queue drained in free cycles, reads take priority.
// Optional collision stall counter enabled by defining CP_BUFWRAP_COLL_CNT_EN.
module cp_bufwrap_arb #(
  parameter int unsigned DW       = 128,
  parameter int unsigned AW       = 7,
  parameter int unsigned NWD      = 4,
  parameter int unsigned WQ_DEPTH = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                        iClk,
  input  logic                        iRsn,
  input  logic                        iWrEn,
  output logic                        oWrRdy,
  input  logic [NWD-1:0]              iWdSel,
  input  logic [AW-1:0]               iWrAddr,
  input  logic [DW-1:0]               iWrDt,
  input  logic                        iRdEn,
  output logic                        oRdRdy,
  input  logic [AW-1:0]               iRdAddr,
  output logic                        oRdVld,
  output logic [DW-1:0]               oRdDt,
  output logic [$clog2(WQ_DEPTH):0]   oWqCnt,
  output logic [15:0]                 oCollCnt,
  output logic                        oCsn,
  output logic                        oWrn,
  output logic [NWD-1:0]              oWdSel,
  output logic [AW-1:0]               oAddr,
  output logic [DW-1:0]               oWrDt,
  input  logic [DW-1:0]               iRdDt
);

  localparam int unsigned PW = $clog2(WQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]  q_addr   [WQ_DEPTH];
  logic [NWD-1:0] q_wdseln [WQ_DEPTH];
  logic [DW-1:0]  q_data   [WQ_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [RD_LAT-1:0] vld_sr;

  logic full;
  logic coll;
  logic rd_rdy;
  logic rd_acc;
  logic push;
  logic pop;

  // Collision: read address matches any occupied queue slot.
  always_comb begin
    coll = 1'b0;
    for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - rd_ptr)) < count) && (q_addr[i] == iRdAddr)) begin
        coll = 1'b1;
      end
    end
  end

  assign full   = (count == CW'(WQ_DEPTH));
  assign rd_rdy = !full && !coll;
  assign oWrRdy = !full;
  assign oRdRdy = rd_rdy;
  assign oWqCnt = count;

  assign rd_acc = iRdEn && rd_rdy && iRsn;
  assign pop    = !rd_acc && (count != '0);
  assign push   = iWrEn && !full && (|iWdSel);

  // Port arbitration: accepted read, else drain head, else idle levels.
  always_comb begin
    oCsn   = 1'b1;
    oWrn   = 1'b1;
    oWdSel = '1;
    oAddr  = '0;
    oWrDt  = '0;
    if (rd_acc) begin
      oCsn  = 1'b0;
      oAddr = iRdAddr;
    end else if (pop) begin
      oCsn   = 1'b0;
      oWrn   = 1'b0;
      oAddr  = q_addr[rd_ptr];
      oWdSel = q_wdseln[rd_ptr];
      oWrDt  = q_data[rd_ptr];
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
        q_addr[i]   <= '0;
        q_wdseln[i] <= '1;
        q_data[i]   <= '0;
      end
    end else begin
      if (push) begin
        q_addr[wr_ptr]   <= iWrAddr;
        q_wdseln[wr_ptr] <= ~iWdSel;
        q_data[wr_ptr]   <= iWrDt;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Read return pipeline tracks SRAM latency, then captures data for one pulse.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      vld_sr <= '0;
      oRdVld <= 1'b0;
      oRdDt  <= '0;
    end else begin
      vld_sr <= RD_LAT'({vld_sr, rd_acc});
      oRdVld <= vld_sr[RD_LAT-1];
      if (vld_sr[RD_LAT-1]) begin
        oRdDt <= iRdDt;
      end
    end
  end

`ifdef CP_BUFWRAP_COLL_CNT_EN
  logic [15:0] coll_cnt;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      coll_cnt <= '0;
    end else if (iRdEn && coll && (coll_cnt != 16'hFFFF)) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end

  assign oCollCnt = coll_cnt;
`else
  assign oCollCnt = 16'h0;
`endif

endmodule

// File: tb/tb_cp_bufwrap_arb.sv
// Bench for cp_bufwrap_arb: queue-level reference model plus behavioural SRAM macro.
module tb_cp_bufwrap_arb;

  localparam int unsigned DW       = 128;
  localparam int unsigned AW       = 7;
  localparam int unsigned NWD      = 4;
  localparam int unsigned WQ_DEPTH = 4;
  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned LW       = DW / NWD;
  localparam int unsigned CW       = $clog2(WQ_DEPTH) + 1;

  logic           iClk = 1'b0;
  logic           iRsn = 1'b0;
  logic           iWrEn = 1'b0;
  logic           oWrRdy;
  logic [NWD-1:0] iWdSel = '0;
  logic [AW-1:0]  iWrAddr = '0;
  logic [DW-1:0]  iWrDt = '0;
  logic           iRdEn = 1'b0;
  logic           oRdRdy;
  logic [AW-1:0]  iRdAddr = '0;
  logic           oRdVld;
  logic [DW-1:0]  oRdDt;
  logic [CW-1:0]  oWqCnt;
  logic [15:0]    oCollCnt;
  logic           oCsn;
  logic           oWrn;
  logic [NWD-1:0] oWdSel;
  logic [AW-1:0]  oAddr;
  logic [DW-1:0]  oWrDt;
  logic [DW-1:0]  iRdDt;

  cp_bufwrap_arb #(.DW(DW), .AW(AW), .NWD(NWD), .WQ_DEPTH(WQ_DEPTH), .RD_LAT(RD_LAT)) dut (
    .iClk(iClk), .iRsn(iRsn), .iWrEn(iWrEn), .oWrRdy(oWrRdy), .iWdSel(iWdSel),
    .iWrAddr(iWrAddr), .iWrDt(iWrDt), .iRdEn(iRdEn), .oRdRdy(oRdRdy), .iRdAddr(iRdAddr),
    .oRdVld(oRdVld), .oRdDt(oRdDt), .oWqCnt(oWqCnt), .oCollCnt(oCollCnt), .oCsn(oCsn),
    .oWrn(oWrn), .oWdSel(oWdSel), .oAddr(oAddr), .oWrDt(oWrDt), .iRdDt(iRdDt)
  );

  always #5 iClk = ~iClk;

  // Behavioural SpSram macro with active-low controls.
  logic [DW-1:0] sram    [2**AW] = '{default: '0};
  logic [DW-1:0] rd_pipe [RD_LAT] = '{default: '0};
  assign iRdDt = rd_pipe[RD_LAT-1];

  always @(posedge iClk) begin
    if (!oCsn && !oWrn) begin
      for (int l = 0; l < NWD; l++) begin
        if (!oWdSel[l]) sram[oAddr][l*LW +: LW] <= oWrDt[l*LW +: LW];
      end
    end
    rd_pipe[0] <= (!oCsn && oWrn) ? sram[oAddr] : '0;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  typedef struct packed {
    logic [AW-1:0]  a;
    logic [NWD-1:0] s;
    logic [DW-1:0]  d;
  } wr_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } ret_t;

  // Reference model: pending writes, architectural memory, committed memory, expected returns.
  wr_t           pend [$];
  ret_t          rets [$];
  logic [DW-1:0] arch_mem    [2**AW] = '{default: '0};
  logic [DW-1:0] drained_mem [2**AW] = '{default: '0};
  logic [DW-1:0] exp_rddt = '0;
  int            coll_m = 0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  logic          rst_drv = 1'b0;
  logic          last_racc;
  logic          last_wacc;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                          input logic [NWD-1:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int l = 0; l < NWD; l++) if (s[l]) r[l*LW +: LW] = d[l*LW +: LW];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'((DW + 31) / 32); i++) r = (r << 32) | DW'($urandom());
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic we, input logic [NWD-1:0] ws, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    logic full, coll, exp_wrrdy, exp_rdrdy, exp_vld, exp_csn, exp_wrn;
    logic [NWD-1:0] exp_wdsel;
    logic [AW-1:0]  exp_addr;
    logic [DW-1:0]  exp_wrdt;
    logic [15:0]    exp_coll;
    @(negedge iClk);
    iRsn = rst_drv; iWrEn = we; iWdSel = ws; iWrAddr = wa; iWrDt = wd; iRdEn = re; iRdAddr = ra;
    if (!rst_drv) begin
      pend.delete();
      rets.delete();
      for (int i = 0; i < 2**AW; i++) arch_mem[i] = drained_mem[i];
      exp_rddt = '0;
      coll_m = 0;
    end
    #1;
    full = (pend.size() == WQ_DEPTH);
    coll = 1'b0;
    foreach (pend[i]) if (pend[i].a == ra) coll = 1'b1;
    exp_wrrdy = !full;
    exp_rdrdy = !full && !coll;
    last_racc = re && exp_rdrdy && rst_drv;
    last_wacc = we && exp_wrrdy && rst_drv;
    exp_vld = 1'b0;
    if (rets.size() != 0 && rets[0].due == cyc) begin
      exp_vld = 1'b1;
      exp_rddt = rets[0].d;
      void'(rets.pop_front());
    end
    exp_csn = 1'b1; exp_wrn = 1'b1; exp_wdsel = '1; exp_addr = '0; exp_wrdt = '0;
    if (last_racc) begin
      exp_csn = 1'b0; exp_addr = ra;
    end else if (rst_drv && pend.size() != 0) begin
      exp_csn = 1'b0; exp_wrn = 1'b0; exp_addr = pend[0].a; exp_wdsel = ~pend[0].s;
      exp_wrdt = pend[0].d;
    end
`ifdef CP_BUFWRAP_COLL_CNT_EN
    exp_coll = 16'(coll_m);
`else
    exp_coll = 16'h0;
`endif
    chk("wr_rdy",   DW'(oWrRdy),   DW'(exp_wrrdy));
    chk("rd_rdy",   DW'(oRdRdy),   DW'(exp_rdrdy));
    chk("rd_vld",   DW'(oRdVld),   DW'(exp_vld));
    chk("rd_dt",    oRdDt,         exp_rddt);
    chk("wq_cnt",   DW'(oWqCnt),   DW'(pend.size()));
    chk("coll_cnt", DW'(oCollCnt), DW'(exp_coll));
    chk("csn",      DW'(oCsn),     DW'(exp_csn));
    chk("wrn",      DW'(oWrn),     DW'(exp_wrn));
    chk("wdsel",    DW'(oWdSel),   DW'(exp_wdsel));
    chk("addr",     DW'(oAddr),    DW'(exp_addr));
    if (exp_csn || !exp_wrn) chk("wr_dt", oWrDt, exp_wrdt);
    if (rst_drv) begin
      if (last_racc) begin
        rets.push_back('{cyc + int'(RD_LAT) + 1, arch_mem[ra]});
      end else if (pend.size() != 0) begin
        drained_mem[pend[0].a] = merge(drained_mem[pend[0].a], pend[0].d, pend[0].s);
        void'(pend.pop_front());
      end
      if (last_wacc && ws != '0) begin
        arch_mem[wa] = merge(arch_mem[wa], wd, ws);
        pend.push_back('{wa, ws, wd});
      end
      if (re && coll && coll_m != 16'hFFFF) coll_m++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           we, re;
    logic [NWD-1:0] ws;
    logic [AW-1:0]  wa, ra;
    logic [DW-1:0]  a5;
    int             tries;

    // Reset held with both requests active
    rst_drv = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, '1, AW'(3), rnd_data(), 1'b1, AW'(3));
    rst_drv = 1'b1;
    idle(2);

    // Full-lane write, drain in idle, read back
    a5 = {(DW/8){8'hA5}};
    step(1'b1, 4'hF, 7'h05, a5, 1'b0, '0);
    idle(1);
    step(1'b0, '0, '0, '0, 1'b1, 7'h05);
    idle(RD_LAT + 2);

    // Continuous reads starve the queue until it fills and forces a drain
    tries = 0;
    for (int n = 0; n < 5; n++) begin
      do begin
        step(1'b1, 4'hF, 7'h20, rnd_data(), 1'b1, 7'h10);
        tries++;
      end while (!last_wacc && tries < 40);
    end
    chk("fill_budget", DW'(tries < 40), DW'(1'b1));
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, 7'h10);
    idle(6);

    // Partial-lane write followed by colliding read
    step(1'b1, 4'b0010, 7'h33, rnd_data(), 1'b0, '0);
    tries = 0;
    do begin
      step(1'b0, '0, '0, '0, 1'b1, 7'h33);
      tries++;
    end while (!last_racc && tries < 8);
    chk("coll_budget", DW'(tries < 8), DW'(1'b1));
    idle(RD_LAT + 2);

    // Empty lane select is acknowledged but never written
    step(1'b1, 4'h0, 7'h05, rnd_data(), 1'b0, '0);
    idle(2);
    step(1'b0, '0, '0, '0, 1'b1, 7'h05);
    idle(RD_LAT + 2);

    // Randomised traffic over a small address window
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 99) < 45);
      re = ($urandom_range(0, 99) < 50);
      ws = ($urandom_range(0, 9) == 0) ? '0 : NWD'($urandom());
      wa = AW'($urandom_range(0, 7));
      ra = AW'($urandom_range(0, 7));
      if (we && re && wa == ra) we = 1'b0;
      step(we, ws, wa, rnd_data(), re, ra);
    end
    idle(8);

    // Reset with three queued writes and a read in flight
    step(1'b1, 4'hF, 7'h40, rnd_data(), 1'b1, 7'h01);
    step(1'b1, 4'hF, 7'h41, rnd_data(), 1'b1, 7'h02);
    step(1'b1, 4'hF, 7'h42, rnd_data(), 1'b1, 7'h03);
    rst_drv = 1'b0;
    step(1'b0, '0, '0, '0, 1'b0, '0);
    step(1'b1, '1, '0, '0, 1'b1, '0);
    rst_drv = 1'b1;
    idle(RD_LAT + 3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(7'h40 + i));
    idle(RD_LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cp_bufwrap_arb.md
Name: cp_bufwrap_arb

Overview:
Parametrised single-port SRAM buffer wrapper with a posted-write queue and read-priority arbitration. Writes are queued and drained into SRAM in idle or forced cycles. Reads take the port immediately and return registered data with a valid strobe. The block drives an external SpSram-style macro (active-low Csn/Wrn/WdSel) and replaces the fixed 128x128 wrapper for buffers of any width and depth.

Parameters:
DW, 128, data width; must be divisible by NWD
AW, 7, address width (depth = 2**AW)
NWD, 4, word-select lanes, each DW/NWD bits
WQ_DEPTH, 4, write-queue entries; power of 2, >= 2
RD_LAT, 1, SRAM read latency in cycles, >= 1

Ports:
iClk  in  1  clock, rising edge
iRsn  in  1  reset, asynchronous, active-low
iWrEn  in  1  write request
oWrRdy  out  1  write accepted when iWrEn & oWrRdy
iWdSel  in  NWD  lane select, active high
iWrAddr  in  AW  write address
iWrDt  in  DW  write data
iRdEn  in  1  read request
oRdRdy  out  1  read accepted when iRdEn & oRdRdy
iRdAddr  in  AW  read address
oRdVld  out  1  one-cycle read-data valid pulse
oRdDt  out  DW  registered read data
oWqCnt  out  clog2(WQ_DEPTH)+1  queue occupancy
oCollCnt  out  16  collision stall counter (optional feature)
oCsn  out  1  SRAM chip select, 0 = selected
oWrn  out  1  SRAM 0 = write, 1 = read
oWdSel  out  NWD  SRAM lane select, 0 = selected
oAddr  out  AW  SRAM address
oWrDt  out  DW  SRAM write data
iRdDt  in  DW  SRAM read data, valid RD_LAT cycles after read issue

Behaviour:
- Clock iClk; reset iRsn asynchronous, active-low. Assertion at any time, including mid-drain or mid-read, flushes the queue, clears the read pipeline and drops pending writes.
- Reset values: oWrRdy=1, oRdRdy=1, oRdVld=0, oRdDt=0, oWqCnt=0, oCollCnt=0, oCsn=1, oWrn=1, oWdSel=all 1, oAddr=0, oWrDt=0.
- Write queue: FIFO of {addr, ~wdsel, data}, wrapping read/write pointers.
  - oWrRdy = (count < WQ_DEPTH), taken from registered state; there is no pass-through when full.
  - Accepted write with iWdSel == 0 is acknowledged and discarded, not enqueued.
- oRdRdy = 0 if the queue is full, or if iRdAddr matches the address of any valid queue entry (collision). Otherwise oRdRdy = 1.
- Per-cycle port arbitration, combinational on SRAM outputs:
  1. Accepted read: oCsn=0, oWrn=1, oAddr=iRdAddr, oWdSel=all 1.
  2. Else, queue not empty: pop head; oCsn=0, oWrn=0, oAddr/oWdSel/oWrDt from head.
  3. Else idle: reset-value levels.
- A full queue or a collision therefore forces a drain cycle. Reads resume once the blocking entries have drained.
- Push and pop in the same cycle leave count unchanged. A push into an empty queue is not drained in the same cycle; earliest drain is the next cycle.
- Read return:
  - RD_LAT-deep valid shift register.
  - When the last stage is set, oRdDt <= iRdDt and oRdVld = 1 for one cycle.
  - Latency from acceptance to oRdVld is RD_LAT+1 cycles.
  - oRdDt holds its value between reads.
  - Back-to-back reads give back-to-back oRdVld pulses.
- Write ordering: same-address writes drain in acceptance order. A read never returns data older than an accepted write to the same address.

Optional Feature:
CP_BUFWRAP_COLL_CNT_EN
- Defined: oCollCnt increments by 1 each cycle iRdEn=1 with oRdRdy=0 caused by an address collision. Full-queue stalls are not counted. The counter saturates at 16'hFFFF and clears only on reset.
- Undefined: oCollCnt tied to 0 and no counter logic is built.

Test Plan:
- Reset with iWrEn=iRdEn=1 held -> all outputs at reset values; oCsn=1 until iRsn=1.
- Write addr 7'h05, data 128'hA5..A5, iWdSel=4'hF, then idle, then read 7'h05 -> drain cycle oCsn=0, oWrn=0, oWdSel=4'h0; read gives oRdVld=1 at RD_LAT+1 with oRdDt=A5..A5.
- Continuous reads to addr 7'h10 while 5 writes to addr 7'h20 are pushed -> oWrRdy=0 after 4 entries; oWqCnt=4; oRdRdy=0 and the queue drains one entry; no read data lost.
- Write 7'h33 with iWdSel=4'b0010, immediately read 7'h33 -> oRdRdy=0 for one cycle; lane 1 write drains with oWdSel=4'b1101; read then accepted; oCollCnt=1 with macro defined, 0 without.
- Write with iWdSel=4'h0 -> oWrRdy handshake completes, oWqCnt stays 0, no SRAM write cycle.
- Assert iRsn=0 with 3 queued writes and a read in flight -> oWqCnt=0, oRdVld never pulses for that read; SRAM contents at the queued addresses unchanged.
